// File: rtl/huffman_stream_packer.sv
// huffman_stream_packer
//   Huffman encoder. A symbol->{len,code} table is programmed over Avalon-MM
//   writes. Symbols arrive on a valid/ready stream, are looked up, and their
//   codes are packed MSB-first into OUT_W-bit words that leave on a
//   valid/ready stream. A flush drains the accumulator and emits a final
//   (possibly partial, possibly empty) word marked with out_last.
// Ports
//   clock, resetn                  : clock, async active-low reset
//   chipselect/write/read          : Avalon-MM slave strobes
//   writedata                      : [SYM_W-1:0] sym, then LEN_W len, then MAX_LEN code
//   readdata                       : [0] busy, [1] err_unmapped, [31:16] words emitted
//   sym_valid/sym_ready/sym_data   : input symbol stream
//   flush                          : one-cycle drain request
//   out_valid/out_ready/out_data   : packed word stream
//   out_bits                       : valid bits in out_data
//   out_last                       : final word of a flush
module huffman_stream_packer #(
  parameter int SYM_W   = 6,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic                         read,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic [SYM_W-1:0]             sym_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(OUT_W+1)-1:0]   out_bits,
  output logic                         out_last
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ENT_W  = LEN_W + MAX_LEN;
  localparam int ACC_W  = 2 * OUT_W;
  localparam int BITS_W = $clog2(OUT_W + 1);
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int SUM_W  = FILL_W + 2;
  localparam int DEPTH  = 2 ** SYM_W;

  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);
  localparam logic [SUM_W-1:0]  MAXL_S  = SUM_W'(MAX_LEN);
  localparam logic [SUM_W-1:0]  ACC_W_S = SUM_W'(ACC_W);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_LAST} state_t;

  // Code table: not reset, survives resetn.
  logic [ENT_W-1:0] table_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (chipselect && write) begin
      table_mem[writedata[SYM_W-1:0]] <= writedata[SYM_W +: ENT_W];
    end
  end

  if (SYM_W + ENT_W < 32) begin : g_wd_spare
    logic unused_wd;
    assign unused_wd = ^writedata[31:SYM_W+ENT_W];
  end

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic               sym_v_q, sym_v_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               ent_v_q, ent_v_d;
  logic [ENT_W-1:0]   ent_q, ent_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [BITS_W-1:0]  out_bits_q, out_bits_d;
  logic               out_last_q, out_last_d;
  logic [15:0]        words_q, words_d;
  logic               err_q, err_d;
  logic [31:0]        readdata_q, readdata_d;

  logic               pending, busy, fits, accept, out_hs;
  logic               emit_full, last_load, append;
  logic [SUM_W-1:0]   reserve;
  logic [LEN_W-1:0]   ent_len;
  logic [MAX_LEN-1:0] ent_code;
  logic [ACC_W-1:0]   acc_e;
  logic [FILL_W-1:0]  fill_e, shamt;

  always_comb begin
    pending = sym_v_q | ent_v_q;
    busy    = (state_q != ST_RUN) | (fill_q != '0) | pending | out_valid_q;

    // Space is reserved for every lookup in flight (up to two), so the
    // accumulator cannot overflow even if the sink stalls indefinitely.
    reserve = (sym_v_q ? MAXL_S : '0) + (ent_v_q ? MAXL_S : '0);
    fits    = ({2'b00, fill_q} + reserve + MAXL_S) <= ACC_W_S;

    sym_ready = en_q & (state_q == ST_RUN) & ~flush & fits;
    accept    = sym_valid & sym_ready;
    out_hs    = out_valid_q & out_ready;

    sym_v_d = accept;
    sym_d   = accept ? sym_data : sym_q;
    ent_v_d = sym_v_q;
    ent_d   = sym_v_q ? table_mem[sym_q] : ent_q;

    ent_len  = ent_q[LEN_W-1:0];
    ent_code = ent_q[ENT_W-1:LEN_W] & ~({MAX_LEN{1'b1}} << ent_len);
    append   = ent_v_q & (ent_len != '0);

    // Full word leaves first; the new code then lands below the reduced fill.
    emit_full = (fill_q >= OUT_W_F) & (~out_valid_q | out_ready);
    acc_e     = emit_full ? (acc_q << OUT_W) : acc_q;
    fill_e    = emit_full ? (fill_q - OUT_W_F) : fill_q;
    shamt     = ACC_W_F - fill_e - FILL_W'(ent_len);

    last_load = (state_q == ST_LAST) & ~(out_valid_q & out_last_q)
              & (~out_valid_q | out_ready);

    acc_d  = append ? (acc_e | (ACC_W'(ent_code) << shamt)) : acc_e;
    fill_d = append ? (fill_e + FILL_W'(ent_len)) : fill_e;
    if (last_load) begin
      acc_d  = '0;
      fill_d = '0;
    end

    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    if (emit_full) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: OUT_W];
      out_bits_d  = BITS_W'(OUT_W);
      out_last_d  = 1'b0;
    end else if (last_load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: OUT_W];
      out_bits_d  = BITS_W'(fill_q);
      out_last_d  = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (!pending && fill_q < OUT_W_F) state_d = ST_LAST;
      ST_LAST:  if (out_hs && out_last_q) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    en_d    = 1'b1;
    words_d = words_q + (out_hs ? 16'd1 : 16'd0);

    // A lookup miss in the same cycle as a status read stays flagged.
    err_d = err_q;
    if (chipselect && read) err_d = 1'b0;
    if (ent_v_q && ent_len == '0) err_d = 1'b1;

    readdata_d = readdata_q;
    if (chipselect && read) begin
      readdata_d = {words_q, 14'b0, err_q, busy};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      en_q        <= 1'b0;
      sym_v_q     <= 1'b0;
      sym_q       <= '0;
      ent_v_q     <= 1'b0;
      ent_q       <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
      words_q     <= '0;
      err_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      sym_v_q     <= sym_v_d;
      sym_q       <= sym_d;
      ent_v_q     <= ent_v_d;
      ent_q       <= ent_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
      words_q     <= words_d;
      err_q       <= err_d;
      readdata_q  <= readdata_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_huffman_stream_packer.sv
// Directed bench for huffman_stream_packer: hand-computed words, status and
// handshake behaviour for the default parameters (SYM_W=6, MAX_LEN=16, OUT_W=32).
module tb_huffman_stream_packer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        chipselect, write, read;
  logic [31:0] writedata, readdata;
  logic        sym_valid, sym_ready;
  logic [5:0]  sym_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic [5:0]  q_bits[$];
  logic        q_last[$];

  logic [5:0]  t4_syms [8] = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd10, 6'd11, 6'd12, 6'd13};
  logic [31:0] st;
  logic [31:0] held;
  logic        have_held;
  logic        saw_stall;

  huffman_stream_packer #(.SYM_W(6), .MAX_LEN(16), .OUT_W(32)) dut (
    .clock(clock), .resetn(resetn),
    .chipselect(chipselect), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bits(out_bits), .out_last(out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (resetn && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bits.push_back(out_bits);
      q_last.push_back(out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] s, input logic [4:0] len, input logic [15:0] code);
    chipselect = 1'b1; write = 1'b1;
    writedata = {5'b0, code, len, s};
    @(posedge clock); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(output logic [31:0] v);
    chipselect = 1'b1; read = 1'b1;
    @(posedge clock); #1;
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
  endtask

  task automatic send(input logic [5:0] s);
    int k = 0;
    sym_valid = 1'b1; sym_data = s;
    @(negedge clock);
    while (!sym_ready && k < 300) begin
      @(negedge clock);
      k++;
    end
    check("send_ready", 32'(sym_ready), 32'd1);
    @(posedge clock); #1;
    sym_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (q_data.size() < n && k < 500) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_count"}, 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_word(input int i, input string tag,
                            input logic [31:0] d, input logic [5:0] b, input logic l);
    if (q_data.size() > i) begin
      check({tag, "_data"}, q_data[i], d);
      check({tag, "_bits"}, 32'(q_bits[i]), 32'(b));
      check({tag, "_last"}, 32'(q_last[i]), 32'(l));
    end else begin
      check({tag, "_present"}, 32'(q_data.size()), 32'(i + 1));
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_bits.delete(); q_last.delete();
  endtask

  initial begin
    resetn = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
    sym_valid = 1'b0; sym_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // 1: four 8-bit codes fill exactly one word
    clear_q();
    wr(6'd5, 5'd8, 16'h00A5);
    repeat (4) send(6'd5);
    wait_words(1, "t1");
    check_word(0, "t1", 32'hA5A5A5A5, 6'd32, 1'b0);

    // 2: 12 bits then flush -> partial last word
    clear_q();
    wr(6'd3, 5'd4, 16'h000C);
    repeat (3) send(6'd3);
    do_flush();
    wait_words(1, "t2");
    check_word(0, "t2", 32'hCCC00000, 6'd12, 1'b1);
    @(negedge clock);
    check("t2_ready_after", 32'(sym_ready), 32'd1);

    // 3: 36 bits -> full word plus 4-bit last word
    clear_q();
    wr(6'd7, 5'd12, 16'h0ABC);
    repeat (3) send(6'd7);
    do_flush();
    wait_words(2, "t3");
    check_word(0, "t3w0", 32'hABCABCAB, 6'd32, 1'b0);
    check_word(1, "t3w1", 32'hC0000000, 6'd4, 1'b1);

    // 4: 16-bit codes under a 20-cycle sink stall, then an empty last word
    clear_q();
    wr(6'd10, 5'd16, 16'h1111);
    wr(6'd11, 5'd16, 16'h2222);
    wr(6'd12, 5'd16, 16'h3333);
    wr(6'd13, 5'd16, 16'h4444);
    out_ready = 1'b0;
    have_held = 1'b0;
    saw_stall = 1'b0;
    held = '0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(t4_syms[i]);
      end
      begin
        repeat (20) begin
          @(negedge clock);
          if (!sym_ready) saw_stall = 1'b1;
          if (out_valid) begin
            if (!have_held) begin
              have_held = 1'b1;
              held = out_data;
            end else begin
              check("t4_stable", out_data, held);
            end
          end
        end
        out_ready = 1'b1;
      end
    join
    check("t4_ready_fell", 32'(saw_stall), 32'd1);
    check("t4_held_word", held, 32'h11112222);
    do_flush();
    wait_words(5, "t4");
    check_word(0, "t4w0", 32'h11112222, 6'd32, 1'b0);
    check_word(1, "t4w1", 32'h33334444, 6'd32, 1'b0);
    check_word(2, "t4w2", 32'h11112222, 6'd32, 1'b0);
    check_word(3, "t4w3", 32'h33334444, 6'd32, 1'b0);
    check_word(4, "t4w4", 32'h00000000, 6'd0, 1'b1);

    // 5: unmapped symbol contributes nothing but flags an error
    clear_q();
    repeat (3) @(negedge clock);
    rd(st);
    check("t5_status_pre", st, 32'h00090000);
    wr(6'd20, 5'd0, 16'h0000);
    wr(6'd21, 5'd8, 16'h005A);
    send(6'd21);
    send(6'd20);
    send(6'd21);
    send(6'd21);
    send(6'd21);
    wait_words(1, "t5");
    check_word(0, "t5", 32'h5A5A5A5A, 6'd32, 1'b0);
    repeat (3) @(negedge clock);
    rd(st);
    check("t5_status_err", st, 32'h000A0002);
    rd(st);
    check("t5_status_clr", st, 32'h000A0000);

    // 6: reset mid-stream discards partial data, keeps the table
    clear_q();
    wr(6'd30, 5'd8, 16'h003C);
    repeat (3) send(6'd30);
    resetn = 1'b0;
    @(negedge clock);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sym_ready", 32'(sym_ready), 32'd0);
    check("t6_rst_readdata", readdata, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    clear_q();
    rd(st);
    check("t6_status", st, 32'h00000000);
    repeat (4) send(6'd5);
    repeat (4) send(6'd30);
    wait_words(2, "t6");
    repeat (10) @(negedge clock);
    check("t6_nwords", 32'(q_data.size()), 32'd2);
    check_word(0, "t6w0", 32'hA5A5A5A5, 6'd32, 1'b0);
    check_word(1, "t6w1", 32'h3C3C3C3C, 6'd32, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
